// File: rtl/pps_ts_pkg.sv
// Shared register offsets and bit positions for the PPS timestamp peripheral.
package pps_ts_pkg;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_STATUS   = 8'h04;
   localparam logic [7:0] REG_COUNTER  = 8'h08;
   localparam logic [7:0] REG_TS_DATA  = 8'h0C;
   localparam logic [7:0] REG_EDGE_CNT = 8'h10;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FLUSH  = 2;

   localparam int STAT_CNT_W = 5;
   localparam int STAT_OVF   = 8;
   localparam int STAT_EMPTY = 9;

endpackage

// File: rtl/pps_ts_fifo.sv
// Timestamp FIFO: pointer pair with an extra wrap bit, head visible combinationally.
module pps_ts_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign count = wr_q - rd_q;
   assign empty = (wr_q == rd_q);
   assign full  = (count == FULL_CNT);
   assign dout  = mem_q[rd_q[AW-1:0]];

   // A pop frees the slot this cycle, so a push at full is still taken.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_ONE;
         if (do_pop)  rd_d = rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pps_timestamp_periph.sv
// iomem-bus PPS capture: free-running counter, PPS synchroniser/edge detect,
// timestamp FIFO, register file and level interrupt.
module pps_timestamp_periph
   import pps_ts_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        pps_in,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pps_prev_q;
   logic                   det_q;
   logic                   pps_s;

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] edge_cnt_q;
   logic        enable_q, irq_en_q, ovf_q, irq_q, ready_q;
   logic [31:0] rdata_q, rdata_d;

   logic       in_win, req, wr_req, rd_req;
   logic [7:0] off;
   logic       ctrl_wr, flush, pop, push, ovf_set, ovf_clr;

   logic [31:0] fifo_dout;
   logic [CW-1:0] fifo_count;
   logic        fifo_full, fifo_empty;

   logic unused_bus;
   assign unused_bus = ^{iomem_wdata[31:9], iomem_wdata[7:3], iomem_wstrb[3:2]};

   assign cnt_d = cnt_q + 32'd1;
   assign pps_s = sync_q[SYNC_STAGES-1];

   assign in_win = (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign req    = iomem_valid && in_win && !ready_q;
   assign wr_req = req && (iomem_wstrb != 4'b0000);
   assign rd_req = req && (iomem_wstrb == 4'b0000);
   assign off    = iomem_addr[7:0];

   assign ctrl_wr = wr_req && (off == REG_CTRL) && iomem_wstrb[0];
   assign flush   = ctrl_wr && iomem_wdata[CTRL_FLUSH];
   assign pop     = rd_req && (off == REG_TS_DATA);
   assign push    = det_q && enable_q;
   // A pop on a full FIFO makes room, so only a push without a pop is dropped.
   assign ovf_set = push && fifo_full && !pop;
   assign ovf_clr = wr_req && (off == REG_STATUS) && iomem_wstrb[1] && iomem_wdata[STAT_OVF];

   pps_ts_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (cnt_q),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rdata_d = '0;
      case (off)
         REG_CTRL:     rdata_d = {30'd0, irq_en_q, enable_q};
         REG_STATUS:   rdata_d = {22'd0, fifo_empty, ovf_q, 3'd0, STAT_CNT_W'(fifo_count)};
         REG_COUNTER:  rdata_d = cnt_q;
         REG_TS_DATA:  rdata_d = fifo_empty ? 32'd0 : fifo_dout;
         REG_EDGE_CNT: rdata_d = edge_cnt_q;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         pps_prev_q <= 1'b0;
         det_q      <= 1'b0;
         cnt_q      <= '0;
         edge_cnt_q <= '0;
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pps_in};
         pps_prev_q <= pps_s;
         det_q      <= pps_s && !pps_prev_q;
         cnt_q      <= cnt_d;
         ready_q    <= req;
         rdata_q    <= rd_req ? rdata_d : 32'd0;
         if (ctrl_wr) begin
            enable_q <= iomem_wdata[CTRL_ENABLE];
            irq_en_q <= iomem_wdata[CTRL_IRQ_EN];
         end
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
         if (det_q) edge_cnt_q <= edge_cnt_q + 32'd1;
         irq_q <= irq_en_q && (fifo_count != '0);
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign irq         = irq_q;

endmodule
